// File: rtl/cache_types.sv
// Types shared by the cache-side memory logic: arbiter FSM states, line owner,
// and default line/address widths.
package cache_types;

   localparam int unsigned DEF_LINE_W = 256;
   localparam int unsigned DEF_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      DONE
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one cacheline-wide physical-memory port between the I-cache and D-cache.
// D side has priority; a streak counter bounds how long a waiting I read can be starved.
module pmem_arbiter
   import cache_types::*;
#(
   parameter int unsigned LINE_W       = DEF_LINE_W,
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   arb_state_t        state_q, state_d;
   logic [3:0]        streak_q, streak_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_resp_q, i_resp_d;
   logic              d_resp_q, d_resp_d;
   arb_owner_t        winner;

   // D wins unless I is waiting and D has already used up its allowed streak.
   function automatic arb_owner_t pick_winner(input logic       i_req,
                                              input logic       d_req,
                                              input logic [3:0] streak);
      arb_owner_t owner;
      if (d_req && !(i_req && (streak == STREAK_MAX))) begin
         owner = OWN_D;
      end else begin
         owner = OWN_I;
      end
      return owner;
   endfunction

   assign winner = pick_winner(i_read, d_read || d_write, streak_q);

   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_resp_d  = 1'b0;
      d_resp_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_read || d_read || d_write) begin
               if (winner == OWN_D) begin
                  state_d = BUSY_D;
                  rd_d    = !d_write;
                  wr_d    = d_write;
                  addr_d  = d_address;
                  wdata_d = d_wdata;
                  if (!i_read) begin
                     streak_d = '0;
                  end else if (streak_q != STREAK_MAX) begin
                     streak_d = streak_q + 4'd1;
                  end
               end else begin
                  state_d  = BUSY_I;
                  rd_d     = 1'b1;
                  wr_d     = 1'b0;
                  addr_d   = i_address;
                  wdata_d  = '0;
                  streak_d = '0;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (pmem_resp) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = DONE;
               if (state_q == BUSY_I) begin
                  i_rdata_d = pmem_rdata;
                  i_resp_d  = 1'b1;
               end else begin
                  // A write-back completes without disturbing the last line read.
                  if (!wr_q) begin
                     d_rdata_d = pmem_rdata;
                  end
                  d_resp_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_resp_q  <= 1'b0;
         d_resp_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_resp_q  <= i_resp_d;
         d_resp_q  <= d_resp_d;
      end
   end

   assign pmem_read    = rd_q;
   assign pmem_write   = wr_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign i_rdata      = i_rdata_q;
   assign i_resp       = i_resp_q;
   assign d_rdata      = d_rdata_q;
   assign d_resp       = d_resp_q;

   illegal_d_rd_wr: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write))
      else $warning("pmem_arbiter: d_read and d_write both high, serving the write");

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a pmem model checks grants and holding stability,
// a monitor pops expected responses from a scoreboard queue.
module tb_pmem_arbiter;

   localparam int unsigned LW = 256;
   localparam int unsigned AW = 32;

   typedef struct packed {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
   } grant_t;

   typedef struct packed {
      logic          is_d;
      logic [LW-1:0] data;
   } resp_t;

   logic          clk;
   logic          rst_n;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   int            tests;
   int            fails;
   int            pmem_lat;
   int            spur_req;
   grant_t        exp_grant[$];
   resp_t         exp_resp[$];
   logic [LW-1:0] mem [logic [AW-1:0]];
   logic [LW-1:0] exp_d_rdata;

   pmem_arbiter #(
      .LINE_W      (LW),
      .ADDR_W      (AW),
      .MAX_D_STREAK(4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_read      (i_read),
      .i_address   (i_address),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_address   (d_address),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .pmem_read   (pmem_read),
      .pmem_write  (pmem_write),
      .pmem_address(pmem_address),
      .pmem_wdata  (pmem_wdata),
      .pmem_rdata  (pmem_rdata),
      .pmem_resp   (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Physical memory model: verifies each new grant against the expected queue,
   // checks the request stays stable while held, answers after pmem_lat extra cycles.
   initial begin
      int     cnt;
      int     spur_done;
      grant_t cur;
      grant_t g;
      cnt        = 0;
      spur_done  = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      cur        = '0;
      forever begin
         @(negedge clk);
         pmem_resp = 1'b0;
         if (pmem_read || pmem_write) begin
            cnt++;
            if (cnt == 1) begin
               cur = '{pmem_read, pmem_write, pmem_address, pmem_wdata};
               if (exp_grant.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_grant: got rd=%0b wr=%0b addr=%0h, expected no grant",
                           pmem_read, pmem_write, pmem_address);
               end else begin
                  g = exp_grant.pop_front();
                  check("grant", {pmem_read, pmem_write, pmem_address, g.wr ? pmem_wdata : {LW{1'b0}}},
                        {g.rd, g.wr, g.addr, g.wr ? g.wdata : {LW{1'b0}}});
               end
            end else begin
               check("pmem_hold", {pmem_read, pmem_write, pmem_address, pmem_wdata},
                     {cur.rd, cur.wr, cur.addr, cur.wdata});
            end
            if (cnt == pmem_lat + 1) begin
               pmem_resp = 1'b1;
               if (pmem_write) begin
                  mem[pmem_address] = pmem_wdata;
                  pmem_rdata = {32{8'hEE}};
               end else begin
                  pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : {8{pmem_address}};
               end
            end
         end else begin
            cnt = 0;
            if (spur_req != spur_done) begin
               spur_done  = spur_req;
               pmem_resp  = 1'b1;
               pmem_rdata = {32{8'h5A}};
            end
         end
      end
   end

   // Response monitor: every resp pulse must match the head of the scoreboard.
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (i_resp || d_resp) begin
            if (exp_resp.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b, expected none", i_resp, d_resp);
            end else begin
               r = exp_resp.pop_front();
               check("resp", {i_resp, d_resp, r.is_d ? d_rdata : i_rdata}, {!r.is_d, r.is_d, r.data});
            end
         end
      end
   end

   task automatic expect_txn(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                             input logic [LW-1:0] wd, input logic [LW-1:0] rdata);
      resp_t r;
      exp_grant.push_back('{!wr, wr, addr, wd});
      if (is_d && !wr) exp_d_rdata = rdata;
      r = '{is_d, (is_d && wr) ? exp_d_rdata : rdata};
      exp_resp.push_back(r);
   endtask

   task automatic wait_resp(input logic is_d, input int bound, output int cycles);
      cycles = 0;
      for (int n = 1; n <= bound; n++) begin
         @(negedge clk);
         if ((is_d ? d_resp : i_resp) == 1'b1) begin
            cycles = n;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no %s resp within %0d cycles, expected one", is_d ? "d" : "i", bound);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            c;
      int            nresp;
      logic [LW-1:0] w2040;
      logic [LW-1:0] w3000;
      logic [LW-1:0] w6000;
      w2040       = {8{32'h1234_5678}};
      w3000       = {8{32'hCAFE_0003}};
      w6000       = {8{32'h6006_6006}};
      tests       = 0;
      fails       = 0;
      pmem_lat    = 2;
      spur_req    = 0;
      exp_d_rdata = '0;
      mem[32'h0000_1000] = {32{8'hA5}};

      // Reset with both requests pending: everything zero, then D served first.
      rst_n     = 1'b1;
      i_read    = 1'b1;
      d_read    = 1'b1;
      d_write   = 1'b0;
      i_address = 32'h0000_5000;
      d_address = 32'h0000_4000;
      d_wdata   = '0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_pmem", {pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp}, '0);
      check("reset_i_rdata", i_rdata, '0);
      check("reset_d_rdata", d_rdata, '0);
      expect_txn(1'b1, 1'b0, 32'h0000_4000, '0, {8{32'h0000_4000}});
      expect_txn(1'b0, 1'b0, 32'h0000_5000, '0, {8{32'h0000_5000}});
      rst_n = 1'b1;
      wait_resp(1'b1, 30, c);
      d_read = 1'b0;
      wait_resp(1'b0, 30, c);
      i_read = 1'b0;
      repeat (2) @(negedge clk);

      // Lone I read, pmem answers two cycles after the strobe.
      expect_txn(1'b0, 1'b0, 32'h0000_1000, '0, {32{8'hA5}});
      i_address = 32'h0000_1000;
      i_read    = 1'b1;
      wait_resp(1'b0, 30, c);
      i_read = 1'b0;
      check("i_latency", 32'(c), 32'd4);
      repeat (2) @(negedge clk);

      // D write then read back; inputs scrambled mid-transaction must not leak through.
      pmem_lat = 1;
      expect_txn(1'b1, 1'b1, 32'h0000_2040, w2040, '0);
      d_address = 32'h0000_2040;
      d_wdata   = w2040;
      d_write   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      d_address = 32'hDEAD_0000;
      d_wdata   = ~w2040;
      wait_resp(1'b1, 30, c);
      d_write = 1'b0;
      expect_txn(1'b1, 1'b0, 32'h0000_2040, '0, w2040);
      d_address = 32'h0000_2040;
      d_read    = 1'b1;
      wait_resp(1'b1, 30, c);
      d_read = 1'b0;
      repeat (2) @(negedge clk);

      // Both sides held: grant order D,D,D,D,I twice.
      pmem_lat = 0;
      for (int k = 0; k < 10; k++) begin
         if (k % 5 == 4) expect_txn(1'b0, 1'b0, 32'h0000_0100, '0, {8{32'h0000_0100}});
         else            expect_txn(1'b1, 1'b0, 32'h0000_0200, '0, {8{32'h0000_0200}});
      end
      i_address = 32'h0000_0100;
      d_address = 32'h0000_0200;
      i_read    = 1'b1;
      d_read    = 1'b1;
      nresp     = 0;
      for (int n = 0; n < 200 && nresp < 10; n++) begin
         @(negedge clk);
         if (i_resp || d_resp) nresp++;
      end
      i_read = 1'b0;
      d_read = 1'b0;
      check("streak_resp_count", 32'(nresp), 32'd10);
      repeat (2) @(negedge clk);

      // Reset one cycle into a D write: strobe falls asynchronously, no resp, retry works.
      pmem_lat = 5;
      exp_grant.push_back('{1'b0, 1'b1, 32'h0000_3000, w3000});
      d_address = 32'h0000_3000;
      d_wdata   = w3000;
      d_write   = 1'b1;
      @(negedge clk);
      check("abort_strobe_up", pmem_write, 1'b1);
      #2 rst_n = 1'b0;
      pmem_lat = 1;
      #1;
      check("abort_strobe_drop", {pmem_read, pmem_write, pmem_address, d_resp}, '0);
      exp_d_rdata = '0;
      expect_txn(1'b1, 1'b1, 32'h0000_3000, w3000, '0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_resp(1'b1, 30, c);
      d_write = 1'b0;
      repeat (2) @(negedge clk);

      // Spurious pmem_resp while idle must be ignored.
      spur_req = spur_req + 1;
      repeat (3) @(negedge clk);
      check("spurious_idle", {pmem_read, pmem_write, i_resp, d_resp}, '0);

      // Read and write together: write served, d_rdata untouched, then read it back.
      expect_txn(1'b1, 1'b1, 32'h0000_6000, w6000, '0);
      d_address = 32'h0000_6000;
      d_wdata   = w6000;
      d_read    = 1'b1;
      d_write   = 1'b1;
      wait_resp(1'b1, 30, c);
      d_read  = 1'b0;
      d_write = 1'b0;
      expect_txn(1'b1, 1'b0, 32'h0000_6000, '0, w6000);
      d_read = 1'b1;
      wait_resp(1'b1, 30, c);
      d_read = 1'b0;
      repeat (3) @(negedge clk);

      check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
      check("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
